// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD command host: opcodes, FSM states,
// and image/IRAM geometry.
package lcd_pkg;

  localparam int IMG_W  = 8;
  localparam int ADDR_W = 6;
  localparam int CMD_W  = 4;
  localparam int CNT_W  = 8;
  localparam int SUM_W  = 16;
  localparam int WCNT_W = 7;

  typedef enum logic [CMD_W-1:0] {
    OP_WRITE       = 4'h0,
    OP_SHIFT_UP    = 4'h1,
    OP_SHIFT_DOWN  = 4'h2,
    OP_SHIFT_LEFT  = 4'h3,
    OP_SHIFT_RIGHT = 4'h4,
    OP_MAX         = 4'h5,
    OP_MIN         = 4'h6,
    OP_AVG         = 4'h7,
    OP_ROT_CCW     = 4'h8,
    OP_ROT_CW      = 4'h9,
    OP_MIRROR_X    = 4'hA,
    OP_MIRROR_Y    = 4'hB
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } state_e;

  // Opcodes above MIRROR_Y have no controller meaning.
  function automatic logic op_legal(input logic [CMD_W-1:0] op);
    return op <= CMD_W'(OP_MIRROR_Y);
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Command queue: DEPTH-entry FIFO, pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module lcd_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]               wp_q, wp_d, rp_q, rp_d;
  logic [DEPTH-1:0][W-1:0]   mem_q, mem_d;
  logic                      do_push, do_pop;

  assign empty   = (wp_q == rp_q);
  assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rp_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (do_push) begin
      mem_d[wp_q[AW-1:0]] = wdata;
      wp_d                = wp_q + 1'b1;
    end
    if (do_pop) rp_d = rp_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      mem_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/lcd_cmd_host.sv
// Host-side sequencer for the LCD image controller: queues opcodes, hands them
// over one at a time, and records completion count and IRAM write signature.
module lcd_cmd_host
  import lcd_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  req_cmd,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_valid,
  input  logic              busy,
  input  logic              done,
  input  logic              IRAM_valid,
  input  logic [ADDR_W-1:0] IRAM_A,
  input  logic [IMG_W-1:0]  IRAM_D,
  output logic [CNT_W-1:0]  cmd_count,
  output logic [SUM_W-1:0]  wr_sum,
  output logic [WCNT_W-1:0] wr_cnt,
  output logic              idle,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d, fifo_rdata;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                err_q, err_d;
  logic                fifo_full, fifo_empty, push, pop;
  logic                waiting, complete, tmo_hit;
  logic                unused_iram_a;

  assign unused_iram_a = ^IRAM_A;

  assign push     = req_valid & op_legal(req_cmd);
  assign waiting  = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE);
  assign complete = (state_q == ST_WAIT_DONE) && !busy && done;
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT - 1));

  lcd_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (req_cmd),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Completion beats timeout in WAIT_DONE; in WAIT_ACK timeout wins so the
  // counter can never run past the compare value.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (!fifo_empty && !busy) state_d = ST_ISSUE;
      ST_ISSUE:     state_d = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (tmo_hit) state_d = ST_IDLE;
                    else if (busy) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (complete || tmo_hit) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = (state_q == ST_ISSUE) || (state_q == ST_WAIT_ACK);
    pop       = (state_q == ST_IDLE) && !fifo_empty && !busy;
    idle      = (state_q == ST_IDLE) && fifo_empty;
  end

  always_comb begin
    cmd_d  = pop ? fifo_rdata : cmd_q;
    cnt_d  = complete ? cnt_q + 8'd1 : cnt_q;
    err_d  = err_q | (req_valid & ~op_legal(req_cmd)) | (waiting & tmo_hit & ~complete);
    tmo_d  = tmo_q;
    sum_d  = sum_q;
    wcnt_d = wcnt_q;
    if (state_q == ST_ISSUE) begin
      tmo_d  = '0;
      sum_d  = '0;
      wcnt_d = '0;
    end else if (waiting) begin
      tmo_d = tmo_q + 1'b1;
      if (IRAM_valid) begin
        sum_d = sum_q + {{(SUM_W-IMG_W){1'b0}}, IRAM_D};
        if (wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q  <= '0;
      cnt_q  <= '0;
      sum_q  <= '0;
      wcnt_q <= '0;
      tmo_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      cmd_q  <= cmd_d;
      cnt_q  <= cnt_d;
      sum_q  <= sum_d;
      wcnt_q <= wcnt_d;
      tmo_q  <= tmo_d;
      err_q  <= err_d;
    end
  end

  assign req_ready = ~fifo_full;
  assign cmd       = cmd_q;
  assign cmd_count = cnt_q;
  assign wr_sum    = sum_q;
  assign wr_cnt    = wcnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lcd_cmd_host.sv
// Bench for lcd_cmd_host: table of enqueue vectors, hand-built corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_lcd_cmd_host;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 255;

  logic       clk, reset;
  logic [3:0] req_cmd;
  logic       req_valid, req_ready;
  logic [3:0] cmd;
  logic       cmd_valid, busy, done;
  logic       IRAM_valid;
  logic [5:0] IRAM_A;
  logic [7:0] IRAM_D;
  logic [7:0] cmd_count;
  logic [15:0] wr_sum;
  logic [6:0] wr_cnt;
  logic       idle, err;

  lcd_cmd_host #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_cmd(req_cmd), .req_valid(req_valid),
    .req_ready(req_ready), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
    .done(done), .IRAM_valid(IRAM_valid), .IRAM_A(IRAM_A), .IRAM_D(IRAM_D),
    .cmd_count(cmd_count), .wr_sum(wr_sum), .wr_cnt(wr_cnt), .idle(idle),
    .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] c;
    logic       v;
    logic       rdy;
    logic       er;
    logic       idl;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] mq[$];     // commands accepted but not yet issued
  int         m_cnt = 0;
  logic       m_err = 1'b0;
  bit         rnd_push = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    logic       pv;
    logic [3:0] pc;
    pv = 1'b0;
    pc = 4'h0;
    if (rnd_push) begin
      chk("ready_model", req_ready, mq.size() < DEPTH);
      if ($urandom_range(0, 3) == 0) begin
        pv = 1'b1;
        pc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      end
      req_valid = pv;
      req_cmd   = pc;
    end
    @(posedge clk);
    #1;
    if (pv) begin
      if (pc >= 4'hC) m_err = 1'b1;
      else if (mq.size() < DEPTH) mq.push_back(pc);
    end
  endtask

  task automatic push_cmd(input logic [3:0] c);
    req_valid = 1'b1;
    req_cmd   = c;
    step();
    req_valid = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(c);
  endtask

  // Behaves as the controller for one command: ack after `ack` cycles, nwr
  // IRAM writes (fixed data when dfix >= 0), then a done pulse.
  task automatic serve_one(input int nwr, input int dfix, input int ack);
    int         t, sum;
    logic [3:0] exp_c;
    logic [7:0] d;
    t = 0;
    while (cmd_valid !== 1'b1 && t < 30) begin
      step();
      t++;
    end
    chk("issue_seen", cmd_valid, 1);
    if (cmd_valid !== 1'b1 || mq.size() == 0) return;
    exp_c = mq.pop_front();
    chk("cmd", cmd, exp_c);
    repeat (ack) begin
      step();
      chk("hold_valid", cmd_valid, 1);
      chk("hold_cmd", cmd, exp_c);
    end
    busy = 1'b1;
    sum  = 0;
    for (int i = 0; i < nwr; i++) begin
      d          = (dfix >= 0) ? 8'(dfix) : 8'($urandom_range(0, 255));
      IRAM_valid = 1'b1;
      IRAM_D     = d;
      IRAM_A     = 6'(i);
      sum       += d;
      step();
    end
    IRAM_valid = 1'b0;
    step();
    chk("ack_drop", cmd_valid, 0);
    busy = 1'b0;
    done = 1'b1;
    step();
    done  = 1'b0;
    m_cnt = (m_cnt + 1) % 256;
    chk("cmd_count", cmd_count, m_cnt);
    chk("wr_sum", wr_sum, sum % 65536);
    chk("wr_cnt", wr_cnt, (nwr > 127) ? 127 : nwr);
    chk("err", err, m_err);
  endtask

  task automatic chk_reset_vals();
    chk("rst_cmd", cmd, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_cmd_count", cmd_count, 0);
    chk("rst_wr_sum", wr_sum, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_err", err, 0);
    chk("rst_idle", idle, 1);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    mq.delete();
    m_cnt = 0;
    m_err = 1'b0;
    @(negedge clk) reset = 1'b1;
    step();
  endtask

  vec_t tbl[11];

  initial begin
    int t, n, bad;
    logic [3:0] e;

    tbl[0]  = '{4'h1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{4'hD, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 2; i <= 8; i++)
      tbl[i] = '{4'(i), 1'b1, (i == 8) ? 1'b0 : 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{4'h9, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{4'h3, 1'b0, 1'b0, 1'b1, 1'b0};

    reset = 1'b0; req_cmd = '0; req_valid = 1'b0; busy = 1'b1; done = 1'b0;
    IRAM_valid = 1'b0; IRAM_A = '0; IRAM_D = '0;
    #12;
    chk_reset_vals();
    @(negedge clk) reset = 1'b1;

    // Image load after power-up: busy held, three commands queued.
    push_cmd(4'h2);
    push_cmd(4'h7);
    push_cmd(4'hB);
    bad = 0;
    repeat (67) begin
      step();
      if (cmd_valid !== 1'b0) bad++;
    end
    chk("powerup_block", bad, 0);
    busy = 1'b0;
    repeat (3) serve_one($urandom_range(0, 10), -1, $urandom_range(1, 3));
    chk("powerup_count", cmd_count, 3);
    chk("powerup_idle", idle, 1);

    push_cmd(4'h0);
    serve_one(64, 1, 2);
    chk("write64_idle", idle, 1);

    // Fill the queue with the controller stalled.
    busy = 1'b1;
    foreach (tbl[i]) begin
      req_valid = tbl[i].v;
      req_cmd   = tbl[i].c;
      step();
      if (tbl[i].v) begin
        if (tbl[i].c >= 4'hC) m_err = 1'b1;
        else if (mq.size() < DEPTH) mq.push_back(tbl[i].c);
      end
      chk("tbl_ready", req_ready, tbl[i].rdy);
      chk("tbl_err", err, tbl[i].er);
      chk("tbl_idle", idle, tbl[i].idl);
    end
    req_valid = 1'b0;
    busy = 1'b0;
    step();
    chk("ready_after_pop", req_ready, 1);
    chk("first_issue", cmd_valid, 1);
    while (mq.size() > 0) serve_one($urandom_range(0, 20), -1, $urandom_range(1, 3));
    chk("drain_idle", idle, 1);

    pulse_reset();
    chk("err_cleared_by_reset", err, 0);
    push_cmd(4'hA);
    serve_one(3, -1, 1);

    // Controller never finishes.
    push_cmd(4'h5);
    t = 0;
    while (cmd_valid !== 1'b1 && t < 10) begin
      step();
      t++;
    end
    chk("to_issue", cmd_valid, 1);
    if (mq.size() > 0) begin
      e = mq.pop_front();
      chk("to_cmd", cmd, e);
    end
    busy = 1'b1;
    n = 0;
    while (err !== 1'b1 && n < 1000) begin
      step();
      n++;
    end
    m_err = 1'b1;
    chk("timeout_cycles", n, TIMEOUT + 1);
    chk("timeout_cmd_valid", cmd_valid, 0);
    chk("timeout_idle", idle, 1);
    chk("timeout_count", cmd_count, m_cnt);
    bad = 0;
    repeat (5) begin
      step();
      if (cmd_valid !== 1'b0) bad++;
    end
    chk("timeout_no_reissue", bad, 0);

    // Reset while the controller is mid-command.
    busy = 1'b0;
    push_cmd(4'h1);
    push_cmd(4'h2);
    t = 0;
    while (cmd_valid !== 1'b1 && t < 10) begin
      step();
      t++;
    end
    chk("rw_issue", cmd_valid, 1);
    step();
    busy = 1'b1;
    IRAM_valid = 1'b1;
    IRAM_D = 8'h07;
    repeat (3) step();
    #2 reset = 1'b0;
    #1;
    chk_reset_vals();
    IRAM_valid = 1'b0;
    mq.delete();
    m_cnt = 0;
    m_err = 1'b0;
    @(negedge clk) reset = 1'b1;
    bad = 0;
    repeat (5) begin
      step();
      if (cmd_valid !== 1'b0) bad++;
    end
    busy = 1'b0;
    repeat (3) begin
      step();
      if (cmd_valid !== 1'b0) bad++;
    end
    chk("post_reset_no_issue", bad, 0);
    chk("post_reset_idle", idle, 1);

    // Random traffic with enqueues overlapping issue and completion.
    rnd_push = 1'b1;
    for (int it = 0; it < 30; it++) begin
      t = 0;
      while (mq.size() == 0 && t < 50) begin
        step();
        t++;
      end
      if (mq.size() > 0) serve_one($urandom_range(0, 150), -1, $urandom_range(1, 4));
    end
    rnd_push  = 1'b0;
    req_valid = 1'b0;
    while (mq.size() > 0) serve_one($urandom_range(0, 40), -1, $urandom_range(1, 4));
    step();
    chk("final_idle", idle, 1);
    chk("final_err", err, m_err);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
